// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared CPU package: arbiter FSM state encoding, requester index constants
// and a small helper used to advance the round-robin pointer.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RD_WAIT = 2'd2
    } arb_state_e;

    localparam logic REQ_CORE = 1'b0;  // requester 0: core
    localparam logic REQ_DBG  = 1'b1;  // requester 1: debug / loader

    // With two requesters "the other one" is simply the inverted index.
    function automatic logic other_req(input logic idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/rr_pick_2.sv
// -----------------------------------------------------------------------------
// rr_pick_2
// Combinational two-way round-robin select.
//   req0, req1 : request lines
//   ptr        : favoured requester when both request
//   winner     : index of the selected requester (meaningful when any = 1)
//   any        : at least one request is present
// -----------------------------------------------------------------------------
module rr_pick_2
    import mem_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    output logic winner,
    output logic any
);

    always_comb begin
        any = req0 | req1;
        // A lone requester wins regardless of the pointer; the pointer only
        // breaks ties.
        if (req0 && req1) begin
            winner = ptr;
        end else if (req1) begin
            winner = REQ_DBG;
        end else begin
            winner = REQ_CORE;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-requester round-robin arbiter sitting between the core (requester 0),
// the debug/loader port (requester 1) and the downstream memory controller.
// One transaction is outstanding at a time: IDLE latches the winner, ISSUE
// strobes the memory port for one cycle, RD_WAIT returns read data.
//
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   req*/we*/addr*/wdata*  : requester transaction request (held until ack)
//   ack*/rdata*            : one-cycle completion pulse, read data during ack
//   mem_addr/mem_data      : latched address / write data toward memory
//   mem_we/mem_re          : one-cycle write / read strobes (ISSUE only)
//   mem_q                  : memory read data, valid the cycle after mem_re
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    arb_state_e            state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic                  win_q, win_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    logic pick_win;
    logic pick_any;
    logic done;     // transaction completes this cycle
    logic rd_done;  // ... and it is a read returning mem_q
    logic issue;    // ISSUE cycle, memory strobe active

    rr_pick_2 u_pick (
        .req0   (req0),
        .req1   (req1),
        .ptr    (ptr_q),
        .winner (pick_win),
        .any    (pick_any)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done    = 1'b0;
        rd_done = 1'b0;
        issue   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    win_d   = pick_win;
                    we_d    = (pick_win == REQ_DBG) ? we1    : we0;
                    addr_d  = (pick_win == REQ_DBG) ? addr1  : addr0;
                    wdata_d = (pick_win == REQ_DBG) ? wdata1 : wdata0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                issue = 1'b1;
                if (we_q) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                done    = 1'b1;
                rd_done = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (done) begin
            ptr_d = other_req(win_q);
        end

        // Read data is muxed straight from mem_q during the read ack and
        // captured so the value holds afterwards.
        rdata0_d = (rd_done && win_q == REQ_CORE) ? mem_q : rdata0_q;
        rdata1_d = (rd_done && win_q == REQ_DBG)  ? mem_q : rdata1_q;

        // NOTE: reset is synchronous, so the flops still hold pre-reset state
        // during the first rst cycle; outputs are masked so nothing leaks
        // while rst is high and an interrupted transaction is never acked.
        ack0     = ~rst & done & (win_q == REQ_CORE);
        ack1     = ~rst & done & (win_q == REQ_DBG);
        mem_we   = ~rst & issue & we_q;
        mem_re   = ~rst & issue & ~we_q;
        mem_addr = rst ? '0 : addr_q;
        mem_data = rst ? '0 : wdata_q;
        rdata0   = rst ? '0 : rdata0_d;
        rdata1   = rst ? '0 : rdata1_d;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from values computed before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= REQ_CORE;
            win_q    <= REQ_CORE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed steps followed by random traffic. A transaction-level reference
// model (grant rule, fixed latencies, next-sample time) predicts every output
// each cycle; the bench also plays the memory by driving mem_q.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    localparam int MODE_MANUAL = 0;  // requesters changed only by the script
    localparam int MODE_HOLD   = 1;  // acked requester re-arms with a write
    localparam int MODE_RANDOM = 2;  // random traffic

    logic          clk = 1'b0;
    logic          rst;
    logic          r_req   [2];
    logic          r_we    [2];
    logic [AW-1:0] r_addr  [2];
    logic [DW-1:0] r_wdata [2];
    logic          ack0, ack1, mem_we, mem_re;
    logic [DW-1:0] rdata0, rdata1, mem_data, mem_q;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (r_req[0]),
        .req1     (r_req[1]),
        .we0      (r_we[0]),
        .we1      (r_we[1]),
        .addr0    (r_addr[0]),
        .addr1    (r_addr[1]),
        .wdata0   (r_wdata[0]),
        .wdata1   (r_wdata[1]),
        .ack0     (ack0),
        .ack1     (ack1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .mem_re   (mem_re),
        .mem_q    (mem_q)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    int            cyc = 0;          // index of the most recent rising edge
    int            next_sample = 0;  // earliest edge at which a req is sampled
    bit            t_valid = 0;      // a granted transaction is outstanding
    bit            t_win;
    bit            t_we;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata;
    int            t_issue;          // edge index that starts the ISSUE cycle
    bit            ptr_m = 0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_data = '0;
    logic [DW-1:0] last_rd [2];
    int            grant_q [$];
    int            ack_cyc_q [$];
    int            mode = MODE_MANUAL;
    bit            use_pat = 0;
    logic [DW-1:0] pat = '0;

    task automatic arm(input int r, input bit we);
        r_req[r]   = 1'b1;
        r_we[r]    = we;
        r_addr[r]  = $urandom;
        r_wdata[r] = $urandom;
    endtask

    // One clock: predict the grant for the coming edge, advance, drive mem_q,
    // compare every output, then let the requester policy react.
    task automatic step();
        bit is_issue, e_ack, got_ack;
        int acked;
        got_ack = 0;
        acked   = 0;

        if (rst) begin
            t_valid     = 0;
            ptr_m       = 0;
            last_addr   = '0;
            last_data   = '0;
            last_rd[0]  = '0;
            last_rd[1]  = '0;
            next_sample = cyc + 2;
        end else if (cyc + 1 >= next_sample && (r_req[0] || r_req[1])) begin
            t_win       = (r_req[0] && r_req[1]) ? ptr_m : r_req[1];
            t_we        = r_we[t_win];
            t_addr      = r_addr[t_win];
            t_wdata     = r_wdata[t_win];
            t_issue     = cyc + 1;
            t_valid     = 1;
            // write: ack in ISSUE cycle, one idle cycle; read: one more
            next_sample = t_issue + (t_we ? 2 : 3);
        end

        @(posedge clk);
        cyc++;
        #1 mem_q = use_pat ? pat : DW'($urandom);
        #1;

        is_issue = t_valid && (cyc == t_issue);
        if (is_issue) begin
            last_addr = t_addr;
            last_data = t_wdata;
        end
        e_ack = t_valid && (cyc == t_issue + (t_we ? 0 : 1));
        if (e_ack && !t_we) last_rd[t_win] = mem_q;

        check("mem_we",   mem_we,   is_issue && t_we);
        check("mem_re",   mem_re,   is_issue && !t_we);
        check("mem_addr", mem_addr, last_addr);
        check("mem_data", mem_data, last_data);
        check("ack0",     ack0,     e_ack && t_win == 0);
        check("ack1",     ack1,     e_ack && t_win == 1);
        if (!(e_ack && t_we && t_win == 0)) check("rdata0", rdata0, last_rd[0]);
        if (!(e_ack && t_we && t_win == 1)) check("rdata1", rdata1, last_rd[1]);
        check("ack_excl",    ack0 & ack1,    1'b0);
        check("strobe_excl", mem_we & mem_re, 1'b0);

        if (e_ack) begin
            grant_q.push_back(int'(t_win));
            ack_cyc_q.push_back(cyc);
            ptr_m   = !t_win;
            t_valid = 0;
            got_ack = 1;
            acked   = int'(t_win);
        end

        if (!rst) begin
            if (mode == MODE_HOLD && got_ack) begin
                arm(acked, 1'b1);
            end else if (mode == MODE_RANDOM) begin
                for (int r = 0; r < 2; r++) begin
                    if (got_ack && acked == r) begin
                        if ($urandom_range(0, 9) < 7) arm(r, 1'($urandom_range(0, 1)));
                        else r_req[r] = 1'b0;
                    end else if (t_valid && int'(t_win) == r) begin
                        // dropping req after the grant must not abort it
                        if ($urandom_range(0, 19) == 0) r_req[r] = 1'b0;
                    end else if (!r_req[r] && $urandom_range(0, 9) < 4) begin
                        arm(r, 1'($urandom_range(0, 1)));
                    end
                end
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        mem_q      = '0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        for (int r = 0; r < 2; r++) begin
            r_req[r]   = 1'b0;
            r_we[r]    = 1'b0;
            r_addr[r]  = '0;
            r_wdata[r] = '0;
        end

        // Reset: all outputs zero while rst is high.
        step();
        step();
        check("rst_ack0", ack0, 1'b0);
        check("rst_mem_addr", mem_addr, '0);

        // Write from requester 0 sampled on the first edge with rst low.
        @(negedge clk);
        rst        = 1'b0;
        r_req[0]   = 1'b1;
        r_we[0]    = 1'b1;
        r_addr[0]  = 32'h10;
        r_wdata[0] = 32'hDEAD;
        step();
        check("wr0_mem_we",   mem_we,   1'b1);
        check("wr0_mem_addr", mem_addr, 32'h10);
        check("wr0_mem_data", mem_data, 32'hDEAD);
        check("wr0_ack0",     ack0,     1'b1);
        r_req[0] = 1'b0;
        step();

        // Read from requester 1; memory returns 0x1234 the cycle after mem_re.
        r_req[1]   = 1'b1;
        r_we[1]    = 1'b0;
        r_addr[1]  = 32'h4;
        r_wdata[1] = '0;
        use_pat    = 1;
        pat        = 32'h1234;
        step();
        check("rd1_mem_re",   mem_re,   1'b1);
        check("rd1_mem_addr", mem_addr, 32'h4);
        check("rd1_early_ack1", ack1,   1'b0);
        step();
        check("rd1_ack1",   ack1,   1'b1);
        check("rd1_rdata1", rdata1, 32'h1234);
        check("rd1_ack0",   ack0,   1'b0);
        r_req[1] = 1'b0;
        use_pat  = 0;
        step();

        // Both requesters hold req for writes: grants alternate from 0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        grant_q.delete();
        mode = MODE_HOLD;
        arm(0, 1'b1);
        arm(1, 1'b1);
        for (int i = 0; i < 40 && grant_q.size() < 6; i++) step();
        r_req[0] = 1'b0;
        r_req[1] = 1'b0;
        mode = MODE_MANUAL;
        check("alt_count", grant_q.size(), 6);
        for (int i = 0; i < 6 && i < grant_q.size(); i++)
            check($sformatf("alt_grant%0d", i), grant_q[i], i % 2);
        step();
        step();

        // Only requester 1 active: served every 2 cycles.
        grant_q.delete();
        ack_cyc_q.delete();
        mode = MODE_HOLD;
        arm(1, 1'b1);
        for (int i = 0; i < 20 && grant_q.size() < 3; i++) step();
        r_req[1] = 1'b0;
        mode = MODE_MANUAL;
        check("solo_count", grant_q.size(), 3);
        for (int i = 0; i < 3 && i < grant_q.size(); i++)
            check($sformatf("solo_grant%0d", i), grant_q[i], 1);
        for (int i = 1; i < 3 && i < ack_cyc_q.size(); i++)
            check($sformatf("solo_gap%0d", i), ack_cyc_q[i] - ack_cyc_q[i-1], 2);
        step();
        step();

        // Reset during a read: no ack, pointer back to 0.
        arm(0, 1'b1);
        step();
        r_req[0] = 1'b0;
        step();
        arm(1, 1'b0);
        step();
        check("abort_mem_re", mem_re, 1'b1);
        rst = 1'b1;
        step();
        check("abort_ack1",   ack1,   1'b0);
        check("abort_mem_re_low", mem_re, 1'b0);
        rst = 1'b0;
        arm(0, 1'b1);
        arm(1, 1'b1);
        step();
        check("abort_next_ack0", ack0, 1'b1);

        // Random traffic against the model.
        mode = MODE_RANDOM;
        for (int i = 0; i < 1500; i++) step();

        mode     = MODE_MANUAL;
        r_req[0] = 1'b0;
        r_req[1] = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("final_idle", t_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
